proc_scheduler: RTL and testbench
=================================

Name: proc_scheduler

Overview:
Round-robin process scheduler that sequences the program counter for the multiprogramming OS. It keeps a table of per-process saved PCs and active bits, and counts a per-process instruction quantum. On expiry, yield or kill, it runs the context-switch handshake with the datapath: save registers, pick the next process, restore registers, then load the PC. When no process is active it parks the PC at the OS menu address.

Parameters:
NPROC, 4, number of process slots (power of two)
PID_W, 2, process id width, log2(NPROC)
AW, 12, PC/address width
QUANTUM, 50, retired instructions per time slice (≥2)
IDLE_PC, 12'd34, OS menu address loaded when no process is runnable

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
instr_retire  in  1  one pulse per retired instruction of the current process
cur_pc  in  AW  address of the next instruction of the running process (from PC)
yield  in  1  running process gives up the CPU (syscall/halt)
proc_create  in  1  create request, 1-cycle pulse
create_id  in  PID_W  slot to create
create_pc  in  AW  start PC of the new process
proc_kill  in  1  kill request, 1-cycle pulse
kill_id  in  PID_W  slot to kill
save_ack  in  1  datapath finished saving the register file
restore_ack  in  1  datapath finished restoring the register file
save_req  out  1  level, held until save_ack
save_id  out  PID_W  slot being saved
restore_req  out  1  level, held until restore_ack
restore_id  out  PID_W  slot being restored
pc_load  out  1  1-cycle pulse: PC must take pc_value
pc_value  out  AW  PC to load
cur_id  out  PID_W  running process id
running  out  1  1 while in RUN
create_err  out  1  1-cycle pulse: create targeted an active slot

Behaviour:
- Reset: all active bits 0, all saved_pc 0, state IDLE, quantum counter 0, cur_id 0, every output 0. Reset mid-handshake aborts the handshake; the request drops next cycle.
- All outputs are registered. Each state change takes 1 clock.
- States:
  - IDLE: if any slot is active, go SELECT.
  - RUN: running=1. Counter increments on instr_retire. Exit checks, in priority order:
    1. proc_kill with kill_id==cur_id: go SELECT, no save.
    2. yield: go SAVE.
    3. instr_retire with counter==QUANTUM-1: go SAVE.
    On entering SAVE, latch saved_pc[cur_id]=cur_pc and clear the counter.
  - SAVE: save_req=1, save_id=cur_id until save_ack is sampled high, then go SELECT. A kill of cur_id during SAVE clears its active bit; the handshake still completes.
  - SELECT: one cycle. Search slots cur_id+1, cur_id+2, … mod NPROC, with cur_id checked last. The first active slot becomes next_id; go RESTORE. If no slot is active: pc_load=1, pc_value=IDLE_PC, go IDLE.
  - RESTORE: restore_req=1, restore_id=next_id until restore_ack, then go LOAD. If next_id is killed while in RESTORE, finish the handshake, then go SELECT instead of LOAD.
  - LOAD: pc_load=1, pc_value=saved_pc[next_id], cur_id=next_id, counter=0, go RUN.
- Create (any state): if create_id is inactive, set active and saved_pc=create_pc. If it is already active, the table is unchanged and create_err pulses the next cycle.
- Kill (any state): clears the active bit of kill_id. saved_pc is untouched. Killing an inactive slot is a no-op.
- Create and kill of the same id in the same cycle: kill wins, the slot ends inactive, no create_err. Different ids: both take effect.
- A create in the SELECT cycle is not visible to that cycle's search.
- save_ack or restore_ack outside its handshake is ignored.
- The counter never exceeds QUANTUM-1. Slot index arithmetic wraps modulo NPROC.
- A single active process is re-selected and goes through the full save/restore/load sequence each quantum.

Test Plan:
- Reset, then no creates for 20 cycles → state IDLE, save_req/restore_req/pc_load all 0, running=0.
- Create id0 @0x100 → restore_req with restore_id=0; ack → pc_load=1, pc_value=0x100, cur_id=0, running=1.
- Two processes: id0 @0x100, id1 @0x200, QUANTUM=50. Run 50 retires with cur_pc=0x132 → save_req (save_id=0); ack → restore_id=1 → pc_value=0x200. After 50 more retires → back to id0 with pc_value=0x132.
- yield after 7 retires → save_req the next cycle. Next quantum count starts at 0 (switch after exactly 50 retires).
- Kill cur_id while it is the only process → no save_req; pc_load pulse with pc_value=34, state IDLE.
- Create id2 twice → create_err 1-cycle pulse on the second create, saved_pc unchanged. Create+kill id3 in the same cycle → id3 inactive, and SELECT never picks it.

Source files
------------

// File: rtl/proc_scheduler.sv
// Round-robin process scheduler: per-slot saved PC / active table, instruction
// quantum counter, and the save/select/restore/load context-switch handshake.
module proc_scheduler #(
  parameter int              NPROC   = 4,
  parameter int              PID_W   = 2,
  parameter int              AW      = 12,
  parameter int              QUANTUM = 50,
  parameter logic [AW-1:0]   IDLE_PC = AW'(34)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_retire,
  input  logic [AW-1:0]    cur_pc,
  input  logic             yield,
  input  logic             proc_create,
  input  logic [PID_W-1:0] create_id,
  input  logic [AW-1:0]    create_pc,
  input  logic             proc_kill,
  input  logic [PID_W-1:0] kill_id,
  input  logic             save_ack,
  input  logic             restore_ack,
  output logic             save_req,
  output logic [PID_W-1:0] save_id,
  output logic             restore_req,
  output logic [PID_W-1:0] restore_id,
  output logic             pc_load,
  output logic [AW-1:0]    pc_value,
  output logic [PID_W-1:0] cur_id,
  output logic             running,
  output logic             create_err
);

  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SAVE, S_SELECT, S_RESTORE, S_LOAD} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [PID_W-1:0] cur_id_reg, cur_id_next, next_id_reg, next_id_next;
  logic [NPROC-1:0] active_vec;
  logic [AW-1:0]    saved_pc_vec [NPROC];
  logic             save_pc_en, idle_load, found;
  logic [PID_W-1:0] pick, probe;

  logic             save_req_reg, restore_req_reg, pc_load_reg, running_reg, create_err_reg;
  logic [PID_W-1:0] save_id_reg, restore_id_reg;
  logic [AW-1:0]    pc_value_reg;
  logic             save_req_next, restore_req_next, pc_load_next, running_next, create_err_next;
  logic [PID_W-1:0] save_id_next, restore_id_next;
  logic [AW-1:0]    pc_value_next;

  // Process table: kill beats create; a save latch only touches the running slot.
  genvar gi;
  generate
    for (gi = 0; gi < NPROC; gi++) begin : g_slot
      logic          active_reg;
      logic [AW-1:0] saved_pc_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          active_reg   <= 1'b0;
          saved_pc_reg <= '0;
        end else if (proc_kill && kill_id == PID_W'(gi)) begin
          active_reg <= 1'b0;
        end else if (proc_create && create_id == PID_W'(gi) && !active_reg) begin
          active_reg   <= 1'b1;
          saved_pc_reg <= create_pc;
        end else if (save_pc_en && cur_id_reg == PID_W'(gi)) begin
          saved_pc_reg <= cur_pc;
        end
      end
      assign active_vec[gi]   = active_reg;
      assign saved_pc_vec[gi] = saved_pc_reg;
    end
  endgenerate

  // Rotating search starting after cur_id; cur_id itself is the last candidate.
  always_comb begin
    found = 1'b0;
    pick  = cur_id_reg;
    probe = cur_id_reg;
    for (int i = 1; i <= NPROC; i++) begin
      probe = cur_id_reg + PID_W'(i);
      if (!found && active_vec[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    cur_id_next  = cur_id_reg;
    next_id_next = next_id_reg;
    save_pc_en   = 1'b0;
    idle_load    = 1'b0;
    case (state_reg)
      S_IDLE: if (|active_vec) state_next = S_SELECT;
      S_RUN: begin
        if (proc_kill && kill_id == cur_id_reg) begin
          state_next = S_SELECT;
          count_next = '0;
        end else if (yield || (instr_retire && count_reg == LAST)) begin
          state_next = S_SAVE;
          count_next = '0;
          save_pc_en = 1'b1;
        end else if (instr_retire) begin
          count_next = count_reg + 1'b1;
        end
      end
      S_SAVE: if (save_ack) state_next = S_SELECT;
      S_SELECT: begin
        if (found) begin
          next_id_next = pick;
          state_next   = S_RESTORE;
        end else begin
          idle_load  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RESTORE: begin
        if (restore_ack) begin
          // A slot killed during (or on the last cycle of) the restore is re-selected away.
          if (active_vec[next_id_reg] && !(proc_kill && kill_id == next_id_reg)) begin
            state_next  = S_LOAD;
            cur_id_next = next_id_reg;
          end else begin
            state_next = S_SELECT;
          end
        end
      end
      S_LOAD: begin
        state_next = S_RUN;
        count_next = '0;
      end
      default: state_next = S_IDLE;
    endcase

    save_req_next    = (state_next == S_SAVE);
    save_id_next     = save_req_next ? cur_id_reg : '0;
    restore_req_next = (state_next == S_RESTORE);
    restore_id_next  = restore_req_next ? next_id_next : '0;
    pc_load_next     = (state_next == S_LOAD) || idle_load;
    pc_value_next    = (state_next == S_LOAD) ? saved_pc_vec[next_id_reg] :
                       idle_load ? IDLE_PC : '0;
    running_next     = (state_next == S_RUN);
    create_err_next  = proc_create && active_vec[create_id] &&
                       !(proc_kill && kill_id == create_id);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      count_reg       <= '0;
      cur_id_reg      <= '0;
      next_id_reg     <= '0;
      save_req_reg    <= 1'b0;
      save_id_reg     <= '0;
      restore_req_reg <= 1'b0;
      restore_id_reg  <= '0;
      pc_load_reg     <= 1'b0;
      pc_value_reg    <= '0;
      running_reg     <= 1'b0;
      create_err_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      cur_id_reg      <= cur_id_next;
      next_id_reg     <= next_id_next;
      save_req_reg    <= save_req_next;
      save_id_reg     <= save_id_next;
      restore_req_reg <= restore_req_next;
      restore_id_reg  <= restore_id_next;
      pc_load_reg     <= pc_load_next;
      pc_value_reg    <= pc_value_next;
      running_reg     <= running_next;
      create_err_reg  <= create_err_next;
    end
  end

  assign save_req    = save_req_reg;
  assign save_id     = save_id_reg;
  assign restore_req = restore_req_reg;
  assign restore_id  = restore_id_reg;
  assign pc_load     = pc_load_reg;
  assign pc_value    = pc_value_reg;
  assign cur_id      = cur_id_reg;
  assign running     = running_reg;
  assign create_err  = create_err_reg;

endmodule

// File: tb/tb_proc_scheduler.sv
// Self-checking bench for proc_scheduler: create/kill vector table, directed
// context-switch sequences and a randomized run against a slot-table model.
module tb_proc_scheduler;
  localparam int NPROC = 4;
  localparam int PID_W = 2;
  localparam int AW = 12;
  localparam int QUANTUM = 50;
  localparam logic [AW-1:0] IDLE_PC = 12'd34;

  logic clk, reset, instr_retire, yield, proc_create, proc_kill, save_ack, restore_ack;
  logic [AW-1:0] cur_pc, create_pc, pc_value;
  logic [PID_W-1:0] create_id, kill_id, save_id, restore_id, cur_id;
  logic save_req, restore_req, pc_load, running, create_err;

  proc_scheduler #(.NPROC(NPROC), .PID_W(PID_W), .AW(AW), .QUANTUM(QUANTUM), .IDLE_PC(IDLE_PC)) dut (
    .clk(clk), .reset(reset), .instr_retire(instr_retire), .cur_pc(cur_pc), .yield(yield),
    .proc_create(proc_create), .create_id(create_id), .create_pc(create_pc),
    .proc_kill(proc_kill), .kill_id(kill_id), .save_ack(save_ack), .restore_ack(restore_ack),
    .save_req(save_req), .save_id(save_id), .restore_req(restore_req), .restore_id(restore_id),
    .pc_load(pc_load), .pc_value(pc_value), .cur_id(cur_id), .running(running),
    .create_err(create_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: which slots are live, their resume PCs, who runs, and whether the CPU is parked.
  bit            m_active [NPROC];
  logic [AW-1:0] m_saved  [NPROC];
  int            m_cur;
  bit            m_idle;

  typedef struct {
    logic          create;
    logic [1:0]    cid;
    logic [AW-1:0] cpc;
    logic          kill;
    logic [1:0]    kid;
    logic          exp_err;
    logic          exp_rreq;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick();
    for (int i = 1; i <= NPROC; i++) begin
      int s;
      s = (m_cur + i) % NPROC;
      if (m_active[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPROC; i++) begin
      m_active[i] = 1'b0;
      m_saved[i]  = '0;
    end
    m_cur  = 0;
    m_idle = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_create(input int id, input logic [AW-1:0] pc);
    create_id = PID_W'(id);
    create_pc = pc;
    proc_create = 1'b1;
    step();
    proc_create = 1'b0;
    chk("create_err", create_err, m_active[id]);
    $display("create id=%0d pc=0x%0h err=%0b", id, pc, create_err);
    if (!m_active[id]) begin
      m_active[id] = 1'b1;
      m_saved[id]  = pc;
    end
  endtask

  task automatic do_kill(input int id);
    kill_id = PID_W'(id);
    proc_kill = 1'b1;
    step();
    proc_kill = 1'b0;
    m_active[id] = 1'b0;
    $display("kill id=%0d", id);
  endtask

  // Entered one cycle after the scheduler moved into its selection step.
  task automatic select_tail();
    int nxt;
    int d;
    step();
    nxt = rr_pick();
    if (nxt < 0) begin
      chk("idle_pc_load", pc_load, 1);
      chk("idle_pc_value", pc_value, IDLE_PC);
      chk("idle_restore_req", restore_req, 0);
      chk("idle_running", running, 0);
      step();
      chk("idle_pc_load_pulse", pc_load, 0);
      m_idle = 1'b1;
      $display("switch -> idle pc=0x%0h", IDLE_PC);
    end else begin
      chk("restore_req", restore_req, 1);
      chk("restore_id", restore_id, nxt);
      d = $urandom_range(0, 3);
      repeat (d) begin
        save_ack = 1'($urandom_range(0, 1));
        step();
        save_ack = 1'b0;
        chk("restore_req_hold", restore_req, 1);
      end
      restore_ack = 1'b1;
      step();
      restore_ack = 1'b0;
      chk("load_pc_load", pc_load, 1);
      chk("load_pc_value", pc_value, m_saved[nxt]);
      chk("load_cur_id", cur_id, nxt);
      chk("load_restore_drop", restore_req, 0);
      m_cur = nxt;
      step();
      chk("run_running", running, 1);
      chk("run_pc_load_pulse", pc_load, 0);
      m_idle = 1'b0;
      $display("switch -> pid=%0d pc=0x%0h", nxt, m_saved[nxt]);
    end
  endtask

  task automatic save_handshake();
    int d;
    chk("save_req", save_req, 1);
    chk("save_id", save_id, m_cur);
    chk("save_running", running, 0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      restore_ack = 1'($urandom_range(0, 1));
      step();
      restore_ack = 1'b0;
      chk("save_req_hold", save_req, 1);
    end
    save_ack = 1'b1;
    step();
    save_ack = 1'b0;
    chk("save_req_drop", save_req, 0);
    select_tail();
  endtask

  // nret retires (QUANTUM means expiry), optionally followed by a yield.
  task automatic run_slice(input int nret, input bit y, input logic [AW-1:0] pc, input bit gaps);
    $display("slice pid=%0d retires=%0d yield=%0b pc=0x%0h", m_cur, nret, y, pc);
    cur_pc = pc;
    for (int i = 0; i < nret; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          step();
          chk("gap_save_req", save_req, 0);
        end
      end
      instr_retire = 1'b1;
      step();
      instr_retire = 1'b0;
      if (!y && i == QUANTUM - 1) begin
        chk("expiry_save_req", save_req, 1);
      end else begin
        chk("early_save_req", save_req, 0);
        chk("early_running", running, 1);
      end
    end
    if (y) begin
      yield = 1'b1;
      step();
      yield = 1'b0;
    end
    m_saved[m_cur] = pc;
    save_handshake();
  endtask

  task automatic kill_cur();
    $display("kill running pid=%0d", m_cur);
    kill_id = PID_W'(m_cur);
    proc_kill = 1'b1;
    step();
    proc_kill = 1'b0;
    m_active[m_cur] = 1'b0;
    chk("kill_no_save", save_req, 0);
    chk("kill_running", running, 0);
    select_tail();
  endtask

  task automatic start_from_idle();
    step();
    select_tail();
  endtask

  initial begin
    reset = 1'b1; instr_retire = 1'b0; yield = 1'b0; proc_create = 1'b0; proc_kill = 1'b0;
    save_ack = 1'b0; restore_ack = 1'b0; cur_pc = '0; create_pc = '0; create_id = '0; kill_id = '0;
    vecs[0] = '{1'b1, 2'd2, 12'h222, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 12'h333, 1'b0, 2'd0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 2'd3, 12'h3A3, 1'b1, 2'd3, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 2'd1, 12'h111, 1'b0, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 2'd1, 12'h999, 1'b0, 2'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 2'd0, 12'h000, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 12'h000, 1'b1, 2'd0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 2'd1, 12'h155, 1'b1, 2'd3, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 2'd1, 12'h777, 1'b0, 2'd0, 1'b1, 1'b1};

    do_reset();
    chk("rst_outputs", {save_req, save_id, restore_req, restore_id, pc_load, pc_value, cur_id, running, create_err}, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_quiet", {save_req, restore_req, pc_load, running}, 0);
    end

    // Create/kill table; the scheduler picks slot 2 and waits in restore meanwhile.
    for (int i = 0; i < 10; i++) begin
      proc_create = vecs[i].create; create_id = vecs[i].cid; create_pc = vecs[i].cpc;
      proc_kill = vecs[i].kill; kill_id = vecs[i].kid;
      step();
      proc_create = 1'b0; proc_kill = 1'b0;
      $display("vec %0d create=%0b/%0d kill=%0b/%0d err=%0b rreq=%0b", i, vecs[i].create, vecs[i].cid,
               vecs[i].kill, vecs[i].kid, create_err, restore_req);
      chk("vec_create_err", create_err, vecs[i].exp_err);
      chk("vec_restore_req", restore_req, vecs[i].exp_rreq);
      if (vecs[i].exp_rreq) chk("vec_restore_id", restore_id, 2);
    end
    m_active[1] = 1'b1; m_saved[1] = 12'h155;
    m_active[2] = 1'b1; m_saved[2] = 12'h222;
    restore_ack = 1'b1;
    step();
    restore_ack = 1'b0;
    chk("tbl_pc_value", pc_value, 12'h222);
    chk("tbl_pc_load", pc_load, 1);
    chk("tbl_cur_id", cur_id, 2);
    m_cur = 2; m_idle = 1'b0;
    step();
    chk("tbl_running", running, 1);
    do_create(2, 12'hABC);
    run_slice(3, 1'b1, 12'h230, 1'b1);
    chk("skip_killed_slot3", cur_id, 1);
    run_slice(0, 1'b1, 12'h160, 1'b0);
    chk("back_to_slot2", cur_id, 2);

    // Directed two-process quantum sequence.
    do_reset();
    do_create(0, 12'h100);
    start_from_idle();
    do_create(1, 12'h200);
    run_slice(QUANTUM, 1'b0, 12'h132, 1'b0);
    run_slice(QUANTUM, 1'b0, 12'h2AB, 1'b0);
    run_slice(7, 1'b1, 12'h140, 1'b0);
    run_slice(QUANTUM, 1'b0, 12'h2CD, 1'b1);
    do_kill(1);
    run_slice(QUANTUM, 1'b0, 12'h150, 1'b0);
    kill_cur();

    // Randomized operation against the model.
    for (int it = 0; it < 40; it++) begin
      if (m_idle) begin
        do_create($urandom_range(0, NPROC - 1), AW'($urandom));
        start_from_idle();
      end else begin
        case ($urandom_range(0, 9))
          0, 1: do_create($urandom_range(0, NPROC - 1), AW'($urandom));
          2: do_kill((m_cur + $urandom_range(1, NPROC - 1)) % NPROC);
          default: ;
        endcase
        case ($urandom_range(0, 5))
          0: kill_cur();
          1, 2: run_slice(QUANTUM, 1'b0, AW'($urandom), 1'b1);
          default: run_slice($urandom_range(0, QUANTUM - 1), 1'b1, AW'($urandom), 1'b1);
        endcase
      end
    end

    // Reset in the middle of a save handshake.
    if (m_idle) begin
      do_create(3, 12'h3C0);
      start_from_idle();
    end
    yield = 1'b1;
    step();
    yield = 1'b0;
    chk("pre_rst_save_req", save_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("rst_mid_save_req", save_req, 0);
    chk("rst_mid_running", running, 0);
    step();
    chk("rst_mid_quiet", {save_req, restore_req, pc_load, running}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
